ad_ip_jesd204_tpl_adc_deframer: RTL and testbench

Receive-side transport-layer deframer for the JESD204 ADC TPL. It sits between the JESD204 RX link layer and the ADC channel datapath. It realigns lane octets to the frame boundary marked by the link layer's start-of-frame indication, then maps lane octets back to per-channel 16-bit samples. It also tracks frame-alignment lock and counts alignment errors.

---
 rtl/ad_ip_jesd204_tpl_adc_deframer.sv | 148 ++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_deframer.sv
// JESD204 ADC transport-layer deframer: realigns lane octets to the link SOF
// and maps them to 16-bit channel samples, tracking frame lock and alignment errors.
module ad_ip_jesd204_tpl_adc_deframer #(
    parameter int NUM_LANES    = 8,
    parameter int NUM_CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      link_valid,
    input  logic [NUM_LANES*32-1:0]   link_data,
    input  logic [3:0]                link_sof,
    output logic                      adc_valid,
    output logic [NUM_LANES*32-1:0]   adc_data,
    output logic                      status_lock,
    output logic [7:0]                align_err_count
);

    localparam int DW  = NUM_LANES * 32;
    localparam int DPW = 2 * NUM_LANES / NUM_CHANNELS;
    localparam bit HD  = NUM_LANES > NUM_CHANNELS;
    localparam int H   = HD ? NUM_LANES / NUM_CHANNELS / 2 : 1;
    localparam int OFS = HD ? 32 : 8;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_CHECK,
        ST_LOCKED
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_sof;
    logic [1:0]      r_off;
    logic [DW-1:0]   r_prev;
    logic [DW-1:0]   r_aligned;
    logic            r_v1;
    logic            r_adc_valid;
    logic [DW-1:0]   r_adc_data;
    logic            r_lock;
    logic [7:0]      r_err_cnt;

    logic            w_onehot;
    logic            w_match;
    logic [1:0]      w_sof_idx;
    logic            w_emit;
    logic            w_latch;
    logic            w_err;
    logic [DW-1:0]   w_aligned;
    logic [DW-1:0]   w_mapped;

    assign w_onehot = (link_sof != 4'd0) && ((link_sof & (link_sof - 4'd1)) == 4'd0);
    assign w_match  = (link_sof == r_sof);

    always_comb begin
        w_sof_idx = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (link_sof[b]) w_sof_idx = 2'(b);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_err       = 1'b0;
        w_emit      = 1'b0;
        if (link_valid) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_onehot) begin
                        w_state_nxt = ST_CHECK;
                        w_latch     = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_match) begin
                        w_state_nxt = ST_LOCKED;
                        w_emit      = 1'b1;
                    end else begin
                        w_state_nxt = ST_UNLOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_match) begin
                        w_emit = 1'b1;
                    end else begin
                        w_state_nxt = ST_UNLOCKED;
                        w_err       = 1'b1;
                    end
                end
                default: w_state_nxt = ST_UNLOCKED;
            endcase
        end
    end

    // Frame starts at octet off_r of the previous beat and spills into the current one.
    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        logic [63:0] w_cat;
        assign w_cat = {link_data[n*32 +: 32], r_prev[n*32 +: 32]};
        assign w_aligned[n*32 +: 32] = w_cat[{1'b0, r_off, 3'b000} +: 32];
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        for (genvar j = 0; j < DPW; j++) begin : g_smp
            localparam int K  = j + i * DPW;
            localparam int O0 = HD ? ((i * H + j % H) * 64 + (j / H) * 8) : K * 16;
            assign w_mapped[K*16 + 8 +: 8] = r_aligned[O0 +: 8];
            assign w_mapped[K*16 +: 8]     = r_aligned[O0 + OFS +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_UNLOCKED;
            r_sof       <= '0;
            r_off       <= '0;
            r_prev      <= '0;
            r_aligned   <= '0;
            r_v1        <= 1'b0;
            r_adc_valid <= 1'b0;
            r_adc_data  <= '0;
            r_lock      <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock      <= (w_state_nxt == ST_LOCKED);
            r_v1        <= w_emit;
            r_adc_valid <= r_v1;
            r_adc_data  <= w_mapped;
            if (w_latch) begin
                r_sof <= link_sof;
                r_off <= w_sof_idx;
            end
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (link_valid) begin
                r_prev    <= link_data;
                r_aligned <= w_aligned;
            end
        end
    end

    assign adc_valid       = r_adc_valid;
    assign adc_data        = r_adc_data;
    assign status_lock     = r_lock;
    assign align_err_count = r_err_cnt;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv
// Bench for the ADC deframer: octet-level reference model compared every cycle,
// plus directed frames with hand-computed sample values.
module tb_ad_ip_jesd204_tpl_adc_deframer;

    localparam int NL  = 8;
    localparam int NC  = 4;
    localparam int W   = NL * 32;
    localparam int DPW = 2 * NL / NC;
    localparam int H   = NL / NC / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          lv;
    logic [W-1:0]  ld;
    logic [3:0]    ls;
    logic          av;
    logic [W-1:0]  ad;
    logic          lock;
    logic [7:0]    cnt;

    logic          b_lv;
    logic [63:0]   b_ld;
    logic [3:0]    b_ls;
    logic          b_av;
    logic [63:0]   b_ad;
    logic          b_lock;
    logic [7:0]    b_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_adc_deframer #(.NUM_LANES(NL), .NUM_CHANNELS(NC)) dut (
        .clk(clk), .reset(rst), .link_valid(lv), .link_data(ld), .link_sof(ls),
        .adc_valid(av), .adc_data(ad), .status_lock(lock), .align_err_count(cnt)
    );

    ad_ip_jesd204_tpl_adc_deframer #(.NUM_LANES(2), .NUM_CHANNELS(2)) dut_b (
        .clk(clk), .reset(rst), .link_valid(b_lv), .link_data(b_ld), .link_sof(b_ls),
        .adc_valid(b_av), .adc_data(b_ad), .status_lock(b_lock), .align_err_count(b_cnt)
    );

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference model: frames as octet arrays, lock tracked as a run of matching beats.
    logic [7:0]   m_prev [NL][4];
    logic [7:0]   m_f1   [NL][4];
    logic [3:0]   m_sof;
    int           m_off, m_run, m_cnt, m_pos;
    bit           m_v1, m_v2, m_lock, m_on, m_match;
    logic [W-1:0] m_d2;

    function automatic logic [W-1:0] frame_to_samples();
        logic [W-1:0] r;
        int lane, oct, k;
        r = '0;
        for (int i = 0; i < NC; i++) begin
            for (int j = 0; j < DPW; j++) begin
                lane = 2 * (i * H + j % H);
                oct  = j / H;
                k    = j + i * DPW;
                r[k*16 +: 16] = {m_f1[lane][oct], m_f1[lane+1][oct]};
            end
        end
        return r;
    endfunction

    initial begin
        m_on = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int n = 0; n < NL; n++)
                    for (int q = 0; q < 4; q++) begin
                        m_prev[n][q] = 8'h00;
                        m_f1[n][q]   = 8'h00;
                    end
                m_sof = 4'd0; m_off = 0; m_run = 0; m_cnt = 0;
                m_v1 = 1'b0; m_v2 = 1'b0; m_lock = 1'b0; m_d2 = '0; m_on = 1'b1;
            end else begin
                m_v2 = m_v1;
                m_d2 = frame_to_samples();
                m_v1 = 1'b0;
                if (lv) begin
                    m_match = (ls == m_sof);
                    if (m_run >= 1 && m_match) begin
                        for (int n = 0; n < NL; n++)
                            for (int q = 0; q < 4; q++) begin
                                m_pos = m_off + q;
                                m_f1[n][q] = (m_pos < 4) ? m_prev[n][m_pos] : ld[n*32 + (m_pos-4)*8 +: 8];
                            end
                        m_v1 = 1'b1;
                    end
                    if (m_run == 0) begin
                        if ($countones(ls) == 1) begin
                            m_sof = ls;
                            for (int q = 0; q < 4; q++) if (ls[q]) m_off = q;
                            m_run = 1;
                        end
                    end else if (m_match) begin
                        m_run = 2;
                    end else begin
                        if (m_run == 2 && m_cnt < 255) m_cnt++;
                        m_run = 0;
                    end
                    for (int n = 0; n < NL; n++)
                        for (int q = 0; q < 4; q++) m_prev[n][q] = ld[n*32 + q*8 +: 8];
                    m_lock = (m_run == 2);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                check("adc_valid", W'(av), W'(m_v2));
                check("status_lock", W'(lock), W'(m_lock));
                check("align_err_count", W'(cnt), W'(m_cnt[7:0]));
                if (m_v2) check("adc_data", ad, m_d2);
            end
        end
    end

    function automatic logic [W-1:0] pat(input int b);
        logic [W-1:0] r;
        for (int n = 0; n < NL; n++) r[n*32 +: 32] = {8'(b), 8'(n), 8'(b*3 + n), 8'hC3};
        return r;
    endfunction

    task automatic beat(input logic v, input logic [3:0] s, input logic [W-1:0] d);
        @(negedge clk);
        lv = v; ls = s; ld = d;
    endtask

    task automatic wait_frame(output int lat);
        @(negedge clk);
        lv = 1'b0;
        lat = 1;
        while (!av && lat < 6) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic zero_check(input string tag);
        check({tag, "_valid"}, W'(av), W'(0));
        check({tag, "_lock"}, W'(lock), W'(0));
        check({tag, "_count"}, W'(cnt), W'(0));
        check({tag, "_data"}, ad, '0);
    endtask

    initial begin
        int lat;
        logic [W-1:0] d;
        rst = 1'b1; lv = 1'b0; ls = 4'd0; ld = '0;
        b_lv = 1'b0; b_ls = 4'd0; b_ld = '0;
        @(negedge clk);
        @(negedge clk);
        zero_check("reset");
        check("b_reset_valid", W'(b_av), W'(0));
        rst = 1'b0;

        // Two-lane, two-channel instance: octet stream maps straight to samples.
        @(negedge clk); b_lv = 1'b1; b_ls = 4'b0001; b_ld = {32'h0807_0605, 32'h0403_0201};
        @(negedge clk); b_ld = 64'hFFEE_DDCC_BBAA_9988;
        @(negedge clk); b_lv = 1'b0; lat = 1;
        while (!b_av && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        check("b_latency", W'(lat), W'(2));
        check("b_samples", W'(b_ad), W'(64'h0708_0506_0304_0102));
        check("b_lock", W'(b_lock), W'(1));
        check("b_count", W'(b_cnt), W'(0));

        // First frame after lock, SOF at octet 0.
        d = '0; d[7:0] = 8'h12; d[39:32] = 8'h34;
        beat(1'b1, 4'b0001, d);
        beat(1'b1, 4'b0001, pat(1));
        wait_frame(lat);
        check("t1_latency", W'(lat), W'(2));
        check("t1_sample0", W'(ad[15:0]), W'(16'h1234));
        check("t1_lock", W'(lock), W'(1));
        for (int b = 2; b < 6; b++) beat(1'b1, 4'b0001, pat(b));

        @(negedge clk); rst = 1'b1; lv = 1'b0;
        @(negedge clk); rst = 1'b0;
        zero_check("rst1");

        // SOF at octet 2: frame straddles two beats.
        d = '0; d[31:0] = 32'hBBAA_0000; d[63:32] = 32'h2211_0000;
        beat(1'b1, 4'b0100, d);
        d = '0; d[31:0] = 32'h0000_DDCC; d[63:32] = 32'h0000_4433;
        beat(1'b1, 4'b0100, d);
        wait_frame(lat);
        check("t2_latency", W'(lat), W'(2));
        check("t2_frame", ad, {{(W-64){1'b0}}, 64'hDD44_CC33_BB22_AA11});
        for (int b = 6; b < 13; b++) beat(1'b1, 4'b0100, pat(b));

        for (int b = 0; b < 8; b++) beat((b % 2) == 0, 4'b0100, pat(20 + b));

        // Misplaced SOF while locked.
        beat(1'b1, 4'b0100, pat(29));
        beat(1'b1, 4'b0010, pat(30));
        beat(1'b0, 4'b0000, '0);
        check("t4_lock_drop", W'(lock), W'(0));
        check("t4_count", W'(cnt), W'(1));
        beat(1'b1, 4'b0100, pat(31));
        beat(1'b1, 4'b0100, pat(32));
        wait_frame(lat);
        check("t4_relock_latency", W'(lat), W'(2));
        check("t4_relock", W'(lock), W'(1));
        for (int b = 33; b < 37; b++) beat(1'b1, 4'b0100, pat(b));

        for (int r = 0; r < 300; r++) begin
            beat(1'b1, 4'b0010, pat(r));
            beat(1'b1, 4'b0100, pat(r + 1));
            beat(1'b1, 4'b0100, pat(r + 2));
        end
        beat(1'b0, 4'b0000, '0);
        check("t6_saturated", W'(cnt), W'(255));
        check("t6_locked", W'(lock), W'(1));

        beat(1'b1, 4'b0100, pat(400));
        beat(1'b1, 4'b0100, pat(401));
        @(negedge clk); rst = 1'b1; ld = pat(402);
        @(negedge clk); rst = 1'b0; lv = 1'b0;
        zero_check("t6_reset");
        beat(1'b1, 4'b0100, pat(403));
        beat(1'b0, 4'b0000, '0);
        check("t6_one_beat_lock", W'(lock), W'(0));
        beat(1'b1, 4'b0100, pat(404));
        beat(1'b0, 4'b0000, '0);
        check("t6_two_beat_lock", W'(lock), W'(1));
        @(negedge clk);
        check("t6_frame_out", W'(av), W'(1));

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
